// File: rtl/swu_pkg.sv
// -----------------------------------------------------------------------------
// swu_pkg
// Shared types and helpers for the sliding-window unit read side.
//   state_e   : read-controller FSM states.
//   ofm_dim   : output feature-map size from input size, kernel, stride, pad.
//   min_int   : integer minimum, used for row-credit clamping.
//   buf_addr  : narrow-port buffer address from (row slot, column, fold).
// -----------------------------------------------------------------------------
package swu_pkg;

  typedef enum logic [1:0] {
    WAIT_ROWS = 2'd0,
    ISSUE     = 2'd1,
    DRAIN     = 2'd2
  } state_e;

  function automatic int ofm_dim(input int ifm_dim, input int k,
                                 input int stride, input int pad);
    return (ifm_dim + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int buf_addr(input int row, input int col, input int fold,
                                  input int ifm_dim, input int folds);
    return (row * ifm_dim + col) * folds + fold;
  endfunction

endpackage

// File: rtl/swu_win_counter.sv
// -----------------------------------------------------------------------------
// swu_win_counter
// Chained loop-nest counters for the window walk, outer to inner:
// oy, ox, ky, kx, fold. Advances one beat per step_i; clear_i returns to beat 0.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   step_i                : advance to the next beat
//   clear_i               : restart the frame walk
//   oy_o, fold_o          : current output row and channel fold
//   iy_o, ix_o            : signed input coordinates of the current beat
//   pad_o                 : current beat lies in the zero-pad border
//   row_last_o            : current beat is the last one of output row oy
//   frame_last_o          : current beat is the last one of the frame
// -----------------------------------------------------------------------------
module swu_win_counter #(
  parameter int IFM_DIM = 8,
  parameter int FOLDS   = 4,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int PAD     = 1,
  parameter int OFM     = 8,
  parameter int CW      = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_i,
  input  logic                 clear_i,
  output logic [CW-1:0]        oy_o,
  output logic [CW-1:0]        fold_o,
  output logic signed [CW-1:0] iy_o,
  output logic signed [CW-1:0] ix_o,
  output logic                 pad_o,
  output logic                 row_last_o,
  output logic                 frame_last_o
);

  logic [CW-1:0] oy_q, ox_q, ky_q, kx_q, fold_q;
  logic [CW-1:0] oy_d, ox_d, ky_d, kx_d, fold_d;
  logic          fold_last, kx_last, ky_last, ox_last, oy_last;
  int            iy_int, ix_int;

  assign fold_last = (fold_q == CW'(FOLDS - 1));
  assign kx_last   = (kx_q   == CW'(K - 1));
  assign ky_last   = (ky_q   == CW'(K - 1));
  assign ox_last   = (ox_q   == CW'(OFM - 1));
  assign oy_last   = (oy_q   == CW'(OFM - 1));

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    oy_d   = oy_q;
    ox_d   = ox_q;
    ky_d   = ky_q;
    kx_d   = kx_q;
    fold_d = fold_q;
    if (clear_i) begin
      oy_d   = '0;
      ox_d   = '0;
      ky_d   = '0;
      kx_d   = '0;
      fold_d = '0;
    end else if (step_i) begin
      fold_d = fold_last ? '0 : fold_q + CW'(1);
      if (fold_last) begin
        kx_d = kx_last ? '0 : kx_q + CW'(1);
        if (kx_last) begin
          ky_d = ky_last ? '0 : ky_q + CW'(1);
          if (ky_last) begin
            ox_d = ox_last ? '0 : ox_q + CW'(1);
            if (ox_last) oy_d = oy_last ? '0 : oy_q + CW'(1);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oy_q   <= '0;
      ox_q   <= '0;
      ky_q   <= '0;
      kx_q   <= '0;
      fold_q <= '0;
    end else begin
      oy_q   <= oy_d;
      ox_q   <= ox_d;
      ky_q   <= ky_d;
      kx_q   <= kx_d;
      fold_q <= fold_d;
    end
  end

  always_comb begin
    iy_int = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
    ix_int = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
  end

  assign iy_o         = CW'(iy_int);
  assign ix_o         = CW'(ix_int);
  assign pad_o        = (iy_int < 0) || (iy_int >= IFM_DIM) ||
                        (ix_int < 0) || (ix_int >= IFM_DIM);
  assign oy_o         = oy_q;
  assign fold_o       = fold_q;
  assign row_last_o   = fold_last & kx_last & ky_last & ox_last;
  assign frame_last_o = row_last_o & oy_last;

endmodule

// File: rtl/swu_window_read_ctrl.sv
// -----------------------------------------------------------------------------
// swu_window_read_ctrl
// Read-side sequencer for the sliding-window line buffer. Walks the
// oy/ox/ky/kx/fold loop nest, drives the narrow read port and presents the
// registered read data as a valid/ready stream. Row credits: waits on
// rows_avail and reports rows_consumed back to the writer.
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   rows_avail       : complete rows written this frame
//   rows_consumed    : rows this frame no longer needed
//   ram_addr         : buffer read address (0 while idle or padding)
//   ram_en           : read-stage enable
//   ram_en_q         : output-register enable
//   ram_zeropad      : force buffer output to zero on ram_en_q
//   out_valid        : output register holds a valid beat
//   out_ready        : downstream accepts the beat
//   frame_done       : pulse after the last beat of a frame is accepted
//   stall_cycles     : only with SWU_RD_STALL_CNT_EN defined; saturating
//                      count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module swu_window_read_ctrl
  import swu_pkg::*;
#(
  parameter int IFM_DIM    = 8,
  parameter int FOLDS      = 4,
  parameter int K          = 3,
  parameter int STRIDE     = 1,
  parameter int PAD        = 1,
  parameter int BUF_ROWS   = 4,
  parameter int ADDRWIDTHB = 7,
  localparam int RW        = $clog2(IFM_DIM + 1)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [RW-1:0]         rows_avail,
  output logic [RW-1:0]         rows_consumed,
  output logic [ADDRWIDTHB-1:0] ram_addr,
  output logic                  ram_en,
  output logic                  ram_en_q,
  output logic                  ram_zeropad,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
`ifdef SWU_RD_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int OFM = ofm_dim(IFM_DIM, K, STRIDE, PAD);
  localparam int CW  = $clog2(IFM_DIM + 2 * PAD + K + FOLDS + 1) + 1;

  state_e                  state_q, state_d;
  logic [RW-1:0]           rows_avail_q;
  logic [RW-1:0]           rows_consumed_q;
  logic                    s1_valid_q, s1_pad_q, out_valid_q, frame_done_q;
  logic                    adv, issue_w, read_w, drain_done, row_end;

  logic [CW-1:0]           oy, fold;
  logic signed [CW-1:0]    iy, ix;
  logic                    pad, row_last, frame_last;
  int                      need_rows, consumed_int, row_idx, addr_int;

  swu_win_counter #(
    .IFM_DIM (IFM_DIM),
    .FOLDS   (FOLDS),
    .K       (K),
    .STRIDE  (STRIDE),
    .PAD     (PAD),
    .OFM     (OFM),
    .CW      (CW)
  ) u_cnt (
    .clk          (ap_clk),
    .rst_n        (ap_rst_n),
    .step_i       (issue_w),
    .clear_i      (drain_done),
    .oy_o         (oy),
    .fold_o       (fold),
    .iy_o         (iy),
    .ix_o         (ix),
    .pad_o        (pad),
    .row_last_o   (row_last),
    .frame_last_o (frame_last)
  );

  // A beat moves forward only when the output register is free or draining.
  assign adv        = !out_valid_q || out_ready;
  assign issue_w    = adv && (state_q == ISSUE);
  assign read_w     = adv && s1_valid_q;
  assign row_end    = issue_w && row_last;
  // Stage 1 empty plus an accepted output beat means the final beat just left.
  assign drain_done = (state_q == DRAIN) && !s1_valid_q && out_valid_q && out_ready;

  always_comb begin
    need_rows    = min_int(int'(oy) * STRIDE + K - PAD, IFM_DIM);
    consumed_int = min_int((int'(oy) + 1) * STRIDE - PAD, IFM_DIM);
    if (consumed_int < 0) consumed_int = 0;
    row_idx      = int'(iy) % BUF_ROWS;
    addr_int     = buf_addr(row_idx, int'(ix), int'(fold), IFM_DIM, FOLDS);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_ROWS: if (int'(rows_avail_q) >= need_rows) state_d = ISSUE;
      ISSUE:     if (row_end) state_d = frame_last ? DRAIN : WAIT_ROWS;
      DRAIN:     if (drain_done) state_d = WAIT_ROWS;
      default:   state_d = WAIT_ROWS;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q         <= WAIT_ROWS;
      rows_avail_q    <= '0;
      rows_consumed_q <= '0;
      s1_valid_q      <= 1'b0;
      s1_pad_q        <= 1'b0;
      out_valid_q     <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_avail_q <= rows_avail;
      if (adv) s1_valid_q <= issue_w;
      if (issue_w) s1_pad_q <= pad;
      out_valid_q  <= read_w || (out_valid_q && !out_ready);
      frame_done_q <= drain_done;
      // Full credit is handed back with frame_done, then the count restarts.
      if (drain_done)        rows_consumed_q <= RW'(IFM_DIM);
      else if (frame_done_q) rows_consumed_q <= '0;
      else if (row_end)      rows_consumed_q <= RW'(consumed_int);
    end
  end

  // Pad beats read nothing real, so their address is parked at 0.
  assign ram_addr      = (issue_w && !pad) ? ADDRWIDTHB'(addr_int) : '0;
  assign ram_en        = issue_w;
  assign ram_en_q      = read_w;
  assign ram_zeropad   = s1_pad_q && s1_valid_q;
  assign out_valid     = out_valid_q;
  assign frame_done    = frame_done_q;
  assign rows_consumed = rows_consumed_q;

`ifdef SWU_RD_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_swu_window_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_swu_window_read_ctrl
// Directed bench for swu_window_read_ctrl in the small configuration
// IFM_DIM=4, FOLDS=1, K=3, STRIDE=1, PAD=1 (OFM=4, 144 beats, 36 per row).
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_swu_window_read_ctrl;

  localparam int IFM_DIM    = 4;
  localparam int FOLDS      = 1;
  localparam int K          = 3;
  localparam int STRIDE     = 1;
  localparam int PAD        = 1;
  localparam int BUF_ROWS   = 4;
  localparam int ADDRWIDTHB = 7;
  localparam int RW         = $clog2(IFM_DIM + 1);
  localparam int OFM        = 4;
  localparam int ROW_BEATS  = 36;
  localparam int BEATS      = 144;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n = 1'b0;
  logic [RW-1:0]         rows_avail = '0;
  logic [RW-1:0]         rows_consumed;
  logic [ADDRWIDTHB-1:0] ram_addr;
  logic                  ram_en, ram_en_q, ram_zeropad, out_valid, frame_done;
  logic                  out_ready = 1'b1;
`ifdef SWU_RD_STALL_CNT_EN
  logic [31:0]           stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  // Credit after the last beat of output row r: min((r+1)-1, 4).
  int rc_tab[4] = '{0, 1, 2, 3};

  always #5 ap_clk = ~ap_clk;

  swu_window_read_ctrl #(
    .IFM_DIM    (IFM_DIM),
    .FOLDS      (FOLDS),
    .K          (K),
    .STRIDE     (STRIDE),
    .PAD        (PAD),
    .BUF_ROWS   (BUF_ROWS),
    .ADDRWIDTHB (ADDRWIDTHB)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .rows_avail    (rows_avail),
    .rows_consumed (rows_consumed),
    .ram_addr      (ram_addr),
    .ram_en        (ram_en),
    .ram_en_q      (ram_en_q),
    .ram_zeropad   (ram_zeropad),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .frame_done    (frame_done)
`ifdef SWU_RD_STALL_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  // Beat b decomposes (FOLDS=1) as kx=b%3, ky=(b/3)%3, ox=(b/9)%4, oy=b/36.
  function automatic int beat_iy(input int b);
    return b / ROW_BEATS + (b / K) % K - PAD;
  endfunction

  function automatic int beat_ix(input int b);
    return (b / (K * K)) % OFM + b % K - PAD;
  endfunction

  function automatic bit beat_pad(input int b);
    return beat_iy(b) < 0 || beat_iy(b) >= IFM_DIM || beat_ix(b) < 0 || beat_ix(b) >= IFM_DIM;
  endfunction

  function automatic int beat_addr(input int b);
    return (beat_iy(b) % BUF_ROWS) * IFM_DIM + beat_ix(b);
  endfunction

  task automatic do_reset();
    ap_rst_n   = 1'b0;
    rows_avail = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({ram_en, ram_en_q, ram_zeropad, out_valid, frame_done} !== 5'b0 ||
        ram_addr !== '0 || rows_consumed !== '0) begin
      failures++;
      $display("FAIL %s outputs: en=%b en_q=%b zp=%b valid=%b done=%b addr=%0d rc=%0d, all must be 0",
               tag, ram_en, ram_en_q, ram_zeropad, out_valid, frame_done, ram_addr, rows_consumed);
    end
  endtask

  // Streams one frame (or stops after abort_at issued beats), comparing the
  // issue-side addresses, stage-1 zeropad, stall rule, credits and frame_done.
  task automatic stream_frame(input string tag, input bit toggle, input int abort_at);
    int issue_idx = 0, q_idx = 0, acc = 0, cyc = 0, post = 0, rc_next = -1;
    int rc_exp = 0;
    bit fd_next = 1'b0, fd_exp = 1'b0, fd_seen = 1'b0, clr_next = 1'b0, aborted = 1'b0;
    while (1) begin
      @(negedge ap_clk);
      out_ready  = toggle ? ((cyc % 2) == 0) : 1'b1;
      rows_avail = (issue_idx >= BEATS) ? '0 : RW'(IFM_DIM);
      #1;
      if (rc_next >= 0) begin rc_exp = rc_next; rc_next = -1; end
      if (clr_next) begin rc_exp = 0; clr_next = 1'b0; end
      fd_exp  = fd_next;
      fd_next = 1'b0;
      if (fd_exp) rc_exp = IFM_DIM;
      checks += 2;
      if (frame_done !== fd_exp) begin
        failures++;
        $display("FAIL %s frame_done cyc %0d: got %b expected %b", tag, cyc, frame_done, fd_exp);
      end
      if (rows_consumed !== RW'(rc_exp)) begin
        failures++;
        $display("FAIL %s rows_consumed cyc %0d: got %0d expected %0d", tag, cyc, rows_consumed, rc_exp);
      end
      if (ram_en === 1'b1) begin
        if (issue_idx >= BEATS) begin
          checks++; failures++;
          $display("FAIL %s extra issue: got beat %0d expected at most %0d", tag, issue_idx, BEATS);
        end else begin
          if (!beat_pad(issue_idx)) begin
            checks++;
            if (ram_addr !== ADDRWIDTHB'(beat_addr(issue_idx))) begin
              failures++;
              $display("FAIL %s ram_addr beat %0d: got %0d expected %0d", tag, issue_idx, ram_addr, beat_addr(issue_idx));
            end
          end
          if (issue_idx % ROW_BEATS == ROW_BEATS - 1) rc_next = rc_tab[issue_idx / ROW_BEATS];
        end
        issue_idx++;
      end
      if (ram_en_q === 1'b1) begin
        checks++;
        if (q_idx >= BEATS || ram_zeropad !== beat_pad(q_idx)) begin
          failures++;
          $display("FAIL %s ram_zeropad beat %0d: got %b expected %b", tag, q_idx, ram_zeropad,
                   (q_idx < BEATS) ? beat_pad(q_idx) : 1'b0);
        end
        q_idx++;
      end
      if (out_valid === 1'b1 && !out_ready) begin
        checks++;
        if (ram_en !== 1'b0 || ram_en_q !== 1'b0) begin
          failures++;
          $display("FAIL %s stall cyc %0d: got en=%b en_q=%b expected 0 0", tag, cyc, ram_en, ram_en_q);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        acc++;
        if (acc == BEATS) fd_next = 1'b1;
      end
      if (fd_exp) begin fd_seen = 1'b1; clr_next = 1'b1; end
      if (fd_seen) post++;
      cyc++;
      if (abort_at > 0 && issue_idx >= abort_at) begin aborted = 1'b1; break; end
      if (post >= 4) break;
      if (cyc > 3000) begin
        checks++; failures++;
        $display("FAIL %s timeout: got %0d accepted expected %0d", tag, acc, BEATS);
        break;
      end
    end
    if (!aborted) begin
      checks += 3;
      if (issue_idx != BEATS) begin
        failures++; $display("FAIL %s issued: got %0d expected %0d", tag, issue_idx, BEATS);
      end
      if (q_idx != BEATS) begin
        failures++; $display("FAIL %s ram_en_q count: got %0d expected %0d", tag, q_idx, BEATS);
      end
      if (acc != BEATS) begin
        failures++; $display("FAIL %s accepted: got %0d expected %0d", tag, acc, BEATS);
      end
    end
  endtask

  task automatic test_reset();
    ap_rst_n   = 1'b0;
    rows_avail = RW'(IFM_DIM);
    out_ready  = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    check_all_zero("reset");
    ap_rst_n = 1'b1;
    rows_avail = '0;
  endtask

  task automatic test_full_frame();
    do_reset();
    stream_frame("full", 1'b0, 0);
  endtask

  task automatic test_wait_rows();
    int t;
    bit seen;
    do_reset();
    rows_avail = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ap_clk); #1;
      checks++;
      if (ram_en !== 1'b0) begin
        failures++; $display("FAIL wait_rows idle cyc %0d: got ram_en=%b expected 0", i, ram_en);
      end
    end
    @(negedge ap_clk);
    rows_avail = 2;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 2) begin
      @(negedge ap_clk); #1;
      t++;
      seen = (ram_en === 1'b1);
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL wait_rows start: got no ram_en expected within 2 cycles");
    end
    @(negedge ap_clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL wait_rows latency t+1: got out_valid=%b expected 0", out_valid);
    end
    @(negedge ap_clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL wait_rows latency t+2: got out_valid=%b expected 1", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    stream_frame("toggle", 1'b1, 0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    stream_frame("abort", 1'b0, 50);
    ap_rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    stream_frame("restart", 1'b0, 0);
  endtask

`ifdef SWU_RD_STALL_CNT_EN
  task automatic test_stall_count();
    int t;
    do_reset();
    rows_avail = RW'(IFM_DIM);
    t = 0;
    do begin
      @(negedge ap_clk);
      out_ready = 1'b0;
      #1;
      t++;
    end while (out_valid !== 1'b1 && t < 20);
    repeat (9) begin
      @(negedge ap_clk);
      out_ready = 1'b0;
    end
    @(negedge ap_clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (stall_cycles !== 32'd10) begin
      failures++; $display("FAIL stall_cycles: got %0d expected 10", stall_cycles);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected bench end");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_frame();
    test_wait_rows();
    test_backpressure();
    test_reset_mid_frame();
`ifdef SWU_RD_STALL_CNT_EN
    test_stall_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
